// File: rtl/scrambler_ctrl_pkg.sv
// Shared constants, state encoding and frame configuration payload for the
// 802.11-style scrambler controller.
package scrambler_ctrl_pkg;

   localparam int unsigned LEN_W        = 12;
   localparam int unsigned DBPS_W       = 8;
   localparam int unsigned SEED_W       = 7;
   localparam int unsigned SERVICE_BITS = 16;
   localparam int unsigned TAIL_BITS    = 6;
   // Wide enough for 8 * max(length_bytes) PSDU bits
   localparam int unsigned BCNT_W       = LEN_W + 3;
   localparam int unsigned STATE_W      = 3;

   localparam logic [SEED_W-1:0] SEED_SUBST = 7'h7F;

   localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] S_LOAD    = 3'd1;
   localparam logic [STATE_W-1:0] S_SERVICE = 3'd2;
   localparam logic [STATE_W-1:0] S_PSDU    = 3'd3;
   localparam logic [STATE_W-1:0] S_TAIL    = 3'd4;
   localparam logic [STATE_W-1:0] S_PAD     = 3'd5;
   localparam logic [STATE_W-1:0] S_DONE    = 3'd6;

   typedef struct packed {
      logic [LEN_W-1:0]  length_bytes;
      logic [DBPS_W-1:0] n_dbps;
      logic [SEED_W-1:0] seed;
   } frame_cfg_t;

   // An all-zero seed would lock the LFSR, so it is replaced on load
   function automatic logic [SEED_W-1:0] lfsr_seed(input logic [SEED_W-1:0] s);
      return (s == '0) ? SEED_SUBST : s;
   endfunction

endpackage

// File: rtl/scrambler_ctrl_if.sv
// Bit-serial PSDU input and scrambled output streams with valid/ready handshakes.
interface scrambler_ctrl_if;

   logic in_bit;
   logic in_valid;
   logic in_ready;
   logic out_bit;
   logic out_valid;
   logic out_ready;
   logic out_tail;
   logic out_last;

   // Scrambler side: consumes the PSDU stream, produces the scrambled stream
   modport master (
      input  in_bit, in_valid, out_ready,
      output in_ready, out_bit, out_valid, out_tail, out_last
   );

   // Environment side: MAC upstream and encoder downstream
   modport slave (
      output in_bit, in_valid, out_ready,
      input  in_ready, out_bit, out_valid, out_tail, out_last
   );

endinterface

// File: rtl/scrambler_ctrl_lfsr.sv
// 7-bit scrambler LFSR (x^7 + x^4 + 1); feedback is exposed before the shift
// so the controller can XOR it with the current data bit.
module scr_lfsr
   import scrambler_ctrl_pkg::*;
(
   input  logic              Clk,
   input  logic              reset,
   input  logic              load,
   input  logic              en,
   input  logic [SEED_W-1:0] seed,
   output logic              feedback
);

   logic [SEED_W-1:0] s;

   assign feedback = s[6] ^ s[3];

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         s <= SEED_SUBST;
      end else if (load) begin
         s <= lfsr_seed(seed);
      end else if (en) begin
         s <= {s[5:0], feedback};
      end
   end

endmodule

// File: rtl/scrambler_ctrl.sv
// Frame controller: sequences SERVICE, PSDU, TAIL and PAD bits through the
// scrambler toward the encoder with zero-latency valid/ready flow control.
module scrambler_ctrl
   import scrambler_ctrl_pkg::*;
(
   input  logic              Clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [LEN_W-1:0]  length_bytes,
   input  logic [DBPS_W-1:0] n_dbps,
   input  logic [SEED_W-1:0] seed,
   output logic              busy,
   output logic              done,
   scrambler_ctrl_if.master  bus
);

   localparam logic [BCNT_W-1:0] SVC_LAST  = BCNT_W'(SERVICE_BITS - 1);
   localparam logic [BCNT_W-1:0] TAIL_LAST = BCNT_W'(TAIL_BITS - 1);

   logic [STATE_W-1:0] state, state_nxt;
   frame_cfg_t         cfg, cfg_nxt;
   logic [BCNT_W-1:0]  bit_cnt, bit_cnt_nxt;
   logic [DBPS_W-1:0]  sym_cnt, sym_cnt_nxt;

   logic              lfsr_load;
   logic              lfsr_en;
   logic              lfsr_fb;

   logic              out_valid_c;
   logic              out_bit_c;
   logic              out_tail_c;
   logic              out_last_c;
   logic              in_ready_c;
   logic              busy_c;
   logic              done_c;
   logic              beat_c;

   logic [BCNT_W-1:0] psdu_bits;
   logic              psdu_last;
   logic              sym_last;

   assign psdu_bits = {cfg.length_bytes, 3'b000};
   assign psdu_last = (bit_cnt == psdu_bits - BCNT_W'(1));
   // Symbol-bit counter reaching n_dbps-1 marks a symbol boundary on this beat
   assign sym_last  = (sym_cnt == cfg.n_dbps - DBPS_W'(1));

   scr_lfsr u_lfsr (
      .Clk      (Clk),
      .reset    (reset),
      .load     (lfsr_load),
      .en       (lfsr_en),
      .seed     (cfg.seed),
      .feedback (lfsr_fb)
   );

   // State, configuration and counter registers
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         cfg     <= '0;
         bit_cnt <= '0;
         sym_cnt <= '0;
      end else begin
         state   <= state_nxt;
         cfg     <= cfg_nxt;
         bit_cnt <= bit_cnt_nxt;
         sym_cnt <= sym_cnt_nxt;
      end
   end

   // Next-state, counter and stream output decode
   always_comb begin
      state_nxt   = state;
      cfg_nxt     = cfg;
      bit_cnt_nxt = bit_cnt;
      sym_cnt_nxt = sym_cnt;
      lfsr_load   = 1'b0;
      lfsr_en     = 1'b0;
      out_valid_c = 1'b0;
      out_bit_c   = 1'b0;
      out_tail_c  = 1'b0;
      out_last_c  = 1'b0;
      in_ready_c  = 1'b0;
      beat_c      = 1'b0;
      busy_c      = (state != S_IDLE);
      done_c      = (state == S_DONE);

      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               cfg_nxt.length_bytes = length_bytes;
               cfg_nxt.n_dbps       = n_dbps;
               cfg_nxt.seed         = seed;
               state_nxt            = S_LOAD;
            end
         end
         S_LOAD: begin
            lfsr_load   = 1'b1;
            bit_cnt_nxt = '0;
            sym_cnt_nxt = '0;
            state_nxt   = S_SERVICE;
         end
         S_SERVICE: begin
            out_valid_c = 1'b1;
            out_bit_c   = lfsr_fb;
         end
         S_PSDU: begin
            in_ready_c  = bus.out_ready;
            out_valid_c = bus.in_valid;
            out_bit_c   = bus.in_bit ^ lfsr_fb;
         end
         S_TAIL: begin
            out_valid_c = 1'b1;
            out_tail_c  = 1'b1;
            out_last_c  = sym_last && (bit_cnt == TAIL_LAST);
         end
         S_PAD: begin
            out_valid_c = 1'b1;
            out_bit_c   = lfsr_fb;
            out_last_c  = sym_last;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Everything below advances only on an accepted output beat
      beat_c  = out_valid_c && bus.out_ready;
      lfsr_en = beat_c;
      if (beat_c) begin
         sym_cnt_nxt = sym_last ? '0 : sym_cnt + DBPS_W'(1);
         bit_cnt_nxt = bit_cnt + BCNT_W'(1);
         case (state)
            S_SERVICE: begin
               if (bit_cnt == SVC_LAST) begin
                  bit_cnt_nxt = '0;
                  state_nxt   = (cfg.length_bytes == '0) ? S_TAIL : S_PSDU;
               end
            end
            S_PSDU: begin
               if (psdu_last) begin
                  bit_cnt_nxt = '0;
                  state_nxt   = S_TAIL;
               end
            end
            S_TAIL: begin
               if (bit_cnt == TAIL_LAST) begin
                  bit_cnt_nxt = '0;
                  state_nxt   = sym_last ? S_DONE : S_PAD;
               end
            end
            S_PAD: begin
               bit_cnt_nxt = '0;
               if (sym_last) begin
                  state_nxt = S_DONE;
               end
            end
            default: begin
               bit_cnt_nxt = bit_cnt;
            end
         endcase
      end

      if (abort) begin
         state_nxt   = S_IDLE;
         bit_cnt_nxt = '0;
         sym_cnt_nxt = '0;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_bit   = out_bit_c;
   assign bus.out_tail  = out_tail_c;
   assign bus.out_last  = out_last_c;
   assign busy          = busy_c;
   assign done          = done_c;

endmodule

// File: tb/tb_scrambler_ctrl.sv
// Directed bench for scrambler_ctrl: frame lengths, padding, stalls, abort,
// seed substitution and asynchronous reset against a bench-side scrambler model.
module tb_scrambler_ctrl;

   logic        Clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [11:0] length_bytes;
   logic [7:0]  n_dbps;
   logic [6:0]  seed;
   logic        busy;
   logic        done;

   scrambler_ctrl_if sif ();

   scrambler_ctrl dut (
      .Clk          (Clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .length_bytes (length_bytes),
      .n_dbps       (n_dbps),
      .seed         (seed),
      .busy         (busy),
      .done         (done),
      .bus          (sif)
   );

   always #5 Clk = ~Clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   bit cap_bit[$];
   bit cap_tail[$];
   bit exp_bit[$];
   bit exp_tail[$];
   bit ref_bit[$];

   int last_cyc, last_idx, done_cyc, done_cnt, stall_err, inr_cnt, n_last;
   bit abort_busy, busy_end, fin;

   // PSDU payload: byte k = k*37+5, sent LSB first
   function automatic bit data_bit(input int k);
      logic [7:0] b;
      b = 8'((k / 8) * 37 + 5);
      return b[3'(k % 8)];
   endfunction

   task automatic build_exp(input logic [6:0] sd, input int len, input int dbps);
      logic [6:0] s;
      bit         fb, d, tl;
      int         pad, tot;
      s   = (sd == 7'd0) ? 7'h7F : sd;
      pad = (dbps - ((22 + 8 * len) % dbps)) % dbps;
      tot = 22 + 8 * len + pad;
      exp_bit.delete();
      exp_tail.delete();
      for (int i = 0; i < tot; i++) begin
         d  = 1'b0;
         tl = 1'b0;
         if (i >= 16 && i < 16 + 8 * len) d = data_bit(i - 16);
         else if (i >= 16 + 8 * len && i < 22 + 8 * len) tl = 1'b1;
         fb = s[6] ^ s[3];
         exp_bit.push_back(tl ? 1'b0 : (d ^ fb));
         exp_tail.push_back(tl);
         s = {s[5:0], fb};
      end
   endtask

   function automatic int diff_exp(input int n);
      int e = 0;
      for (int i = 0; i < n; i++)
         if (i >= cap_bit.size() || i >= exp_bit.size() ||
             cap_bit[i] != exp_bit[i] || cap_tail[i] != exp_tail[i]) e++;
      return e;
   endfunction

   function automatic int diff_ref(input int n);
      int e = 0;
      for (int i = 0; i < n; i++)
         if (i >= cap_bit.size() || i >= ref_bit.size() || cap_bit[i] != ref_bit[i]) e++;
      return e;
   endfunction

   task automatic run_frame(input logic [6:0] sd, input int len, input int dbps,
                            input bit stall, input int abort_at, input bit poke);
      int cyc, psdu_k, abort_cyc;
      bit poked, prev_stall, prev_bit, prev_tail, prev_last;
      cap_bit.delete();
      cap_tail.delete();
      last_cyc = -1; last_idx = -1; done_cyc = -1; done_cnt = 0;
      stall_err = 0; inr_cnt = 0; n_last = 0; abort_busy = 1'b1; busy_end = 1'b1;
      cyc = 0; psdu_k = 0; abort_cyc = -1; fin = 1'b0; poked = 1'b0;
      prev_stall = 1'b0; prev_bit = 1'b0; prev_tail = 1'b0; prev_last = 1'b0;
      @(negedge Clk);
      seed = sd; length_bytes = 12'(len); n_dbps = 8'(dbps); start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      while (!fin && cyc < 4000) begin
         sif.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         sif.in_valid  = 1'b1;
         sif.in_bit    = data_bit(psdu_k);
         abort = 1'b0;
         start = 1'b0;
         if (abort_at >= 0 && abort_cyc < 0 && psdu_k == abort_at) begin
            abort = 1'b1; sif.in_valid = 1'b0; abort_cyc = cyc;
         end
         if (poke && !poked && cap_bit.size() > 22 + 8 * len) begin
            start = 1'b1; poked = 1'b1;
         end
         #1;
         if (prev_stall && (!sif.out_valid || sif.out_bit != prev_bit ||
                            sif.out_tail != prev_tail || sif.out_last != prev_last)) stall_err++;
         prev_stall = sif.out_valid && !sif.out_ready;
         prev_bit   = sif.out_bit;
         prev_tail  = sif.out_tail;
         prev_last  = sif.out_last;
         if (sif.in_ready) inr_cnt++;
         if (done) begin done_cnt++; done_cyc = cyc; end
         busy_end = busy;
         if (abort_cyc >= 0 && cyc == abort_cyc + 1) abort_busy = busy;
         if (sif.out_valid && sif.out_ready) begin
            if (sif.out_last) begin
               n_last++;
               if (last_cyc < 0) begin last_cyc = cyc; last_idx = cap_bit.size(); end
            end
            cap_bit.push_back(sif.out_bit);
            cap_tail.push_back(sif.out_tail);
         end
         if (sif.in_valid && sif.in_ready) psdu_k++;
         if ((last_cyc >= 0 && cyc >= last_cyc + 3) || (abort_cyc >= 0 && cyc >= abort_cyc + 6))
            fin = 1'b1;
         cyc++;
         @(negedge Clk);
      end
      check_val("frame_completed", 32'(fin), 32'd1);
      sif.out_ready = 1'b1; sif.in_valid = 1'b0; abort = 1'b0; start = 1'b0;
   endtask

   initial begin
      logic [7:0] first8;
      bit         seen;
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      length_bytes = '0; n_dbps = '0; seed = '0;
      sif.in_bit = 1'b0; sif.in_valid = 1'b0; sif.out_ready = 1'b1;
      #12;
      check_val("reset_outputs", 32'({sif.in_ready, sif.out_valid, sif.out_bit, sif.out_tail,
                                      sif.out_last, busy, done}), 32'd0);
      @(negedge Clk);
      reset = 1'b1;

      // L=100, n_dbps=24: 16+800+6+18 = 840 beats
      run_frame(7'b1011101, 100, 24, 1'b0, -1, 1'b0);
      build_exp(7'b1011101, 100, 24);
      check_val("A_beats", 32'(cap_bit.size()), 32'd840);
      check_val("A_bit_errs", 32'(diff_exp(840)), 32'd0);
      check_val("A_last_idx", 32'(last_idx), 32'd839);
      check_val("A_n_last", 32'(n_last), 32'd1);
      check_val("A_done_lat", 32'(done_cyc - last_cyc), 32'd1);
      check_val("A_done_cnt", 32'(done_cnt), 32'd1);

      // L=0, n_dbps=216: 16+6+194 = 216 beats, PSDU never requested
      run_frame(7'h55, 0, 216, 1'b0, -1, 1'b0);
      build_exp(7'h55, 0, 216);
      check_val("B_beats", 32'(cap_bit.size()), 32'd216);
      check_val("B_in_ready_cnt", 32'(inr_cnt), 32'd0);
      check_val("B_bit_errs", 32'(diff_exp(216)), 32'd0);

      // L=1, n_dbps=48: 48 beats, first without then with random stalls
      run_frame(7'h33, 1, 48, 1'b0, -1, 1'b0);
      build_exp(7'h33, 1, 48);
      check_val("C_beats", 32'(cap_bit.size()), 32'd48);
      check_val("C_bit_errs", 32'(diff_exp(48)), 32'd0);
      ref_bit = cap_bit;
      run_frame(7'h33, 1, 48, 1'b1, -1, 1'b0);
      check_val("D_beats", 32'(cap_bit.size()), 32'd48);
      check_val("D_vs_nostall", 32'(diff_ref(48)), 32'd0);
      check_val("D_stall_changes", 32'(stall_err), 32'd0);
      check_val("D_bit_errs", 32'(diff_exp(48)), 32'd0);
      check_val("D_done_cnt", 32'(done_cnt), 32'd1);

      // Abort after 37 PSDU beats: 16+37 beats captured, then a full rerun
      run_frame(7'h2A, 10, 24, 1'b0, 37, 1'b0);
      build_exp(7'h2A, 10, 24);
      check_val("E_beats", 32'(cap_bit.size()), 32'd53);
      check_val("E_busy_after_abort", 32'(abort_busy), 32'd0);
      check_val("E_done_cnt", 32'(done_cnt), 32'd0);
      check_val("E_bit_errs", 32'(diff_exp(53)), 32'd0);
      ref_bit = cap_bit;
      run_frame(7'h2A, 10, 24, 1'b0, -1, 1'b0);
      check_val("F_beats", 32'(cap_bit.size()), 32'd120);
      check_val("F_prefix", 32'(diff_ref(53)), 32'd0);

      // Seed 0 behaves as 7F; start during PAD ignored. 16+16+6+34 = 72 beats
      run_frame(7'h00, 2, 36, 1'b0, -1, 1'b1);
      check_val("G_beats", 32'(cap_bit.size()), 32'd72);
      first8 = '0;
      for (int i = 0; i < 8 && i < cap_bit.size(); i++) first8[7 - i] = cap_bit[i];
      check_val("G_first8", 32'(first8), 32'(8'b00001110));
      check_val("G_idle_after", 32'(busy_end), 32'd0);
      check_val("G_n_last", 32'(n_last), 32'd1);
      ref_bit = cap_bit;
      run_frame(7'h7F, 2, 36, 1'b0, -1, 1'b0);
      check_val("H_beats", 32'(cap_bit.size()), 32'd72);
      check_val("H_vs_seed0", 32'(diff_ref(72)), 32'd0);

      // Reset asserted mid-TAIL clears outputs asynchronously
      @(negedge Clk);
      seed = 7'h11; length_bytes = 12'd0; n_dbps = 8'd24; start = 1'b1;
      @(negedge Clk);
      start = 1'b0; sif.out_ready = 1'b1; sif.in_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         #1;
         if (sif.out_tail) seen = 1'b1;
         else @(negedge Clk);
      end
      check_val("R_tail_reached", 32'(seen), 32'd1);
      #2 reset = 1'b0;
      #1;
      check_val("R_async_outputs", 32'({sif.in_ready, sif.out_valid, sif.out_bit, sif.out_tail,
                                        sif.out_last, busy, done}), 32'd0);
      @(negedge Clk);
      reset = 1'b1;
      @(negedge Clk);
      #1;
      check_val("R_idle_after_release", 32'({busy, sif.out_valid, done}), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
